// File: rtl/pcie_ltssm_trainer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pcie_ltssm_trainer                                                         |
// | Reduced PCIe LTSSM: Detect.Quiet/Active, Polling.Active/Config, link up.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pcie_ltssm_trainer #(
  parameter int NUM_LANES    = 1,
  parameter int QUIET_TO_CYC = 12000,
  parameter int POLL_TO_CYC  = 24000,
  parameter int TS_TX_MIN    = 1024,
  parameter int TS_RX_REQ    = 8,
  parameter int TS2_TX_AFTER = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_LANES-1:0] phy_rx_elec_idle_i,
  output logic                 phy_detect_req_o,
  input  logic                 phy_detect_done_i,
  input  logic [NUM_LANES-1:0] phy_detect_lanes_i,
  input  logic [NUM_LANES-1:0] rx_ts1_i,
  input  logic [NUM_LANES-1:0] rx_ts2_i,
  output logic                 tx_os_valid_o,
  output logic                 tx_os_type_o,
  input  logic                 tx_os_ready_i,
  input  logic                 train_restart_i,
  output logic [2:0]           state_o,
  output logic [NUM_LANES-1:0] active_lanes_o,
  output logic                 link_up_o,
  output logic                 timeout_o,
  output logic                 en_8b10b_encoder_o
);

  localparam int c_TMR_MAX = (QUIET_TO_CYC > POLL_TO_CYC) ? QUIET_TO_CYC : POLL_TO_CYC;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
  localparam int c_TX_MAX  = (TS_TX_MIN > TS2_TX_AFTER) ? TS_TX_MIN : TS2_TX_AFTER;
  localparam int c_TX_W    = $clog2(c_TX_MAX + 1);
  localparam int c_RX_W    = $clog2(TS_RX_REQ + 1);

  localparam logic [c_TMR_W-1:0] c_QUIET_LAST = c_TMR_W'(QUIET_TO_CYC - 1);
  localparam logic [c_TMR_W-1:0] c_POLL_LAST  = c_TMR_W'(POLL_TO_CYC - 1);
  localparam logic [c_TX_W-1:0]  c_TS1_DONE   = c_TX_W'(TS_TX_MIN);
  localparam logic [c_TX_W-1:0]  c_TS2_DONE   = c_TX_W'(TS2_TX_AFTER);
  localparam logic [c_RX_W-1:0]  c_RX_DONE    = c_RX_W'(TS_RX_REQ);

  typedef enum logic [2:0] {
    S_DQUIET  = 3'd0,
    S_DACTIVE = 3'd1,
    S_PACTIVE = 3'd2,
    S_PCONFIG = 3'd3,
    S_LINKUP  = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_TMR_W-1:0]   r_timer;
  logic [c_TX_W-1:0]    r_tx_cnt;
  logic [NUM_LANES-1:0] r_active;
  logic                 r_detect_req;
  logic                 r_tx_valid;
  logic                 r_tx_type;
  logic                 r_link_up;
  logic                 r_timeout;
  logic                 r_enc;

  state_t               w_next;
  logic                 w_timeout;
  logic                 w_chg;
  logic [NUM_LANES-1:0] w_active_nxt;
  logic [NUM_LANES-1:0] w_rx_full;
  logic [NUM_LANES-1:0] w_rx_nz;
  logic [NUM_LANES-1:0] w_sat;
  logic                 w_all_sat;
  logic                 w_any_sat;
  logic                 w_ts1_done;
  logic                 w_ts2_done;
  logic                 w_tx_inc;

  assign w_sat      = w_rx_full & r_active;
  assign w_all_sat  = (w_sat == r_active);
  assign w_any_sat  = |w_sat;
  assign w_ts1_done = (r_tx_cnt == c_TS1_DONE);
  assign w_ts2_done = (r_tx_cnt == c_TS2_DONE);

  // Post-TS2 transmit counting starts only after some active lane has seen a TS2.
  assign w_tx_inc = r_tx_valid && tx_os_ready_i &&
                    (((r_state == S_PACTIVE) && !w_ts1_done) ||
                     ((r_state == S_PCONFIG) && (|(w_rx_nz & r_active)) && !w_ts2_done));

  always_comb begin
    w_next       = r_state;
    w_timeout    = 1'b0;
    w_active_nxt = r_active;
    case (r_state)
      S_DQUIET: begin
        if ((r_timer == c_QUIET_LAST) || !(&phy_rx_elec_idle_i))
          w_next = S_DACTIVE;
      end
      S_DACTIVE: begin
        if (phy_detect_done_i) begin
          if (|phy_detect_lanes_i) begin
            w_next       = S_PACTIVE;
            w_active_nxt = phy_detect_lanes_i;
          end else begin
            w_next = S_DQUIET;
          end
        end
      end
      S_PACTIVE: begin
        if (w_ts1_done && w_all_sat) begin
          w_next = S_PCONFIG;
        end else if (r_timer == c_POLL_LAST) begin
          if (w_ts1_done && w_any_sat) begin
            w_next       = S_PCONFIG;
            w_active_nxt = w_sat;
          end else begin
            w_next    = S_DQUIET;
            w_timeout = 1'b1;
          end
        end
      end
      S_PCONFIG: begin
        if (w_all_sat && w_ts2_done) begin
          w_next = S_LINKUP;
        end else if (r_timer == c_POLL_LAST) begin
          w_next    = S_DQUIET;
          w_timeout = 1'b1;
        end
      end
      S_LINKUP: begin
        w_next = S_LINKUP;
      end
      default: begin
        w_next = S_DQUIET;
      end
    endcase
    if (train_restart_i) begin
      w_next    = S_DQUIET;
      w_timeout = 1'b0;
    end
    if (w_next == S_DQUIET)
      w_active_nxt = '0;
  end

  // A restart counts as a state change even when already in DQUIET.
  assign w_chg = (w_next != r_state) || train_restart_i;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [c_RX_W-1:0] r_rx_cnt;
    logic              w_hit;

    assign w_hit = r_active[g] && (r_rx_cnt != c_RX_DONE) &&
                   ((r_state == S_PACTIVE) ? (rx_ts1_i[g] || rx_ts2_i[g])
                                           : ((r_state == S_PCONFIG) && rx_ts2_i[g]));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
        r_rx_cnt <= '0;
      else if (w_chg)
        r_rx_cnt <= '0;
      else if ((r_state == S_PACTIVE) && phy_rx_elec_idle_i[g])
        r_rx_cnt <= '0;
      else if (w_hit)
        r_rx_cnt <= r_rx_cnt + 1'b1;
    end

    assign w_rx_full[g] = (r_rx_cnt == c_RX_DONE);
    assign w_rx_nz[g]   = (r_rx_cnt != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_DQUIET;
      r_timer      <= '0;
      r_tx_cnt     <= '0;
      r_active     <= '0;
      r_detect_req <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_type    <= 1'b0;
      r_link_up    <= 1'b0;
      r_timeout    <= 1'b0;
      r_enc        <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_timer  <= w_chg ? '0 : r_timer + 1'b1;
      r_active <= w_active_nxt;
      if (w_chg)
        r_tx_cnt <= '0;
      else if (w_tx_inc)
        r_tx_cnt <= r_tx_cnt + 1'b1;
      // Outputs are decoded from the next state so they line up with state_o.
      r_detect_req <= (w_next == S_DACTIVE) && (r_state != S_DACTIVE);
      r_tx_valid   <= (w_next == S_PACTIVE) || (w_next == S_PCONFIG);
      r_tx_type    <= (w_next == S_PCONFIG);
      r_link_up    <= (w_next == S_LINKUP);
      r_enc        <= (w_next == S_LINKUP);
      r_timeout    <= w_timeout;
    end
  end

  assign state_o            = r_state;
  assign active_lanes_o     = r_active;
  assign phy_detect_req_o   = r_detect_req;
  assign tx_os_valid_o      = r_tx_valid;
  assign tx_os_type_o       = r_tx_type;
  assign link_up_o          = r_link_up;
  assign timeout_o          = r_timeout;
  assign en_8b10b_encoder_o = r_enc;

endmodule
`default_nettype wire
